// File: rtl/f8_gpio_monitor_if.sv
// f8_gpio_monitor_if: gpio pins, character stream and verdict signals between the f8 system, the monitor and its consumer
interface f8_gpio_monitor_if;
  logic [7:0] gpio0pins;
  logic [7:0] gpio1pins;
  logic       trap;
  logic       char_ready;
  logic [7:0] char_data;
  logic       char_valid;
  logic       done;
  logic       pass;
  logic [7:0] status_code;
  logic       overflow;
  logic       timeout;
  modport master (
    input  gpio0pins, gpio1pins, trap, char_ready,
    output char_data, char_valid, done, pass, status_code, overflow, timeout
  );
  modport slave (
    output gpio0pins, gpio1pins, trap, char_ready,
    input  char_data, char_valid, done, pass, status_code, overflow, timeout
  );
endinterface

// File: rtl/f8_gpio_monitor.sv
// f8_gpio_monitor: decodes the f8 gpio console protocol into a character FIFO and a done/pass/code verdict.
// Optional idle timeout is compiled in with F8_GPIOMON_TIMEOUT_EN.
module f8_gpio_monitor #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic power_on_reset,
  f8_gpio_monitor_if.master io
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  typedef enum logic {RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] d_q, code_q, code_d;
  logic m_q, s_q, s_prev_q, t_q;
  logic done_q, done_d, pass_q, pass_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic run, strobe, pop, push_req, push, full, expire;
  logic unused_pins;
  assign unused_pins = ^io.gpio1pins[7:2];
`ifdef F8_GPIOMON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] idle_q, idle_d;
  assign expire = run && !strobe && !t_q && idle_q == IDLE_MAX;
  assign idle_d = strobe ? '0 : run ? idle_q + 1'b1 : idle_q;
  always_ff @(posedge clk) begin
    if (power_on_reset) idle_q <= '0;
    else idle_q <= idle_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif
  always_comb begin
    run      = state_q == RUN;
    strobe   = run && s_q != s_prev_q;
    full     = cnt_q == FULL_CNT;
    pop      = cnt_q != '0 && io.char_ready;
    push_req = strobe && !t_q && !m_q;
    push     = push_req && (!full || pop);
    wr_d     = push ? wr_q + 1'b1 : wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    cnt_d    = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    ovf_d    = ovf_q || (push_req && full && !pop);
    state_d  = state_q;
    done_d   = done_q;
    pass_d   = pass_q;
    code_d   = code_q;
    tmo_d    = tmo_q;
    if (run && t_q) begin
      state_d = DONE;
      done_d  = 1'b1;
      pass_d  = 1'b0;
      code_d  = 8'hFF;
    end else if (strobe && m_q) begin
      state_d = DONE;
      done_d  = 1'b1;
      pass_d  = d_q == 8'h00;
      code_d  = d_q;
    end else if (expire) begin
      state_d = DONE;
      done_d  = 1'b1;
      pass_d  = 1'b0;
      code_d  = 8'hFE;
      tmo_d   = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (power_on_reset) begin
      state_q  <= RUN;
      d_q      <= '0;
      m_q      <= 1'b0;
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
      t_q      <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      code_q   <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_q      <= io.gpio0pins;
      m_q      <= io.gpio1pins[1];
      s_q      <= io.gpio1pins[0];
      s_prev_q <= s_q;
      t_q      <= io.trap;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      code_q   <= code_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= d_q;
  end
  assign io.char_valid  = cnt_q != '0;
  assign io.char_data   = io.char_valid ? mem_q[rd_q] : 8'h00;
  assign io.done        = done_q;
  assign io.pass        = pass_q;
  assign io.status_code = code_q;
  assign io.overflow    = ovf_q;
  assign io.timeout     = tmo_q;
endmodule

// File: tb/tb_f8_gpio_monitor.sv
// tb_f8_gpio_monitor: random and directed console traffic, checked by a queue-based reference model and a pop-side scoreboard monitor
module tb_f8_gpio_monitor;
  localparam int DEPTH = 16;
  localparam int TC = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  f8_gpio_monitor_if io();
  f8_gpio_monitor #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .power_on_reset(rst), .io(io)
  );
  int tests = 0;
  int fails = 0;
  bit tog = 1'b0;
  byte unsigned exp_q[$];
  int occ = 0;
  int idle_cnt = 0;
  bit m_done = 0, m_pass = 0, m_ovf = 0, m_tmo = 0;
  byte unsigned m_code = 0;
  bit cs = 0, cp = 0, cm = 0, ct = 0;
  byte unsigned cd = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bytes sampled at one edge take effect at the next, FIFO tracked as an occupancy count plus a byte queue.
  always @(posedge clk) begin : model
    bit stb, pop, expire;
    if (rst) begin
      occ = 0; exp_q.delete(); idle_cnt = 0;
      m_done = 0; m_pass = 0; m_ovf = 0; m_tmo = 0; m_code = 0;
      cs = 0; cp = 0; cm = 0; ct = 0; cd = 0;
    end else begin
      stb = !m_done && cs != cp;
      pop = occ > 0 && io.char_ready;
      expire = 0;
`ifdef F8_GPIOMON_TIMEOUT_EN
      expire = !m_done && !stb && !ct && idle_cnt == TC - 1;
      idle_cnt = stb ? 0 : m_done ? idle_cnt : idle_cnt + 1;
`endif
      if (!m_done) begin
        if (ct) begin m_done = 1; m_pass = 0; m_code = 8'hFF; end
        else if (stb && cm) begin m_done = 1; m_pass = (cd == 0); m_code = cd; end
        else if (stb) begin
          if (occ < DEPTH || pop) begin exp_q.push_back(cd); occ++; end
          else m_ovf = 1;
        end
        else if (expire) begin m_done = 1; m_pass = 0; m_tmo = 1; m_code = 8'hFE; end
      end
      if (pop) occ--;
      cp = cs; cs = io.gpio1pins[0]; cm = io.gpio1pins[1]; cd = io.gpio0pins; ct = io.trap;
    end
  end

  always @(negedge clk) begin : monitor
    chk("char_valid", io.char_valid, occ != 0);
    if (io.char_valid && io.char_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL char_pop: got %0h expected no character at %0t", io.char_data, $time);
      end else chk("char_data", io.char_data, exp_q.pop_front());
    end
    chk("done", io.done, m_done);
    chk("pass", io.pass, m_pass);
    chk("status_code", io.status_code, m_code);
    chk("overflow", io.overflow, m_ovf);
    chk("timeout", io.timeout, m_tmo);
  end

  task automatic cyc(input logic [7:0] d, input bit t, input bit m, input bit tr, input bit rdy, input bit r);
    io.gpio0pins = d;
    io.gpio1pins = {6'($urandom), m, t};
    io.trap = tr;
    io.char_ready = rdy;
    rst = r;
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [7:0] d, input bit m, input bit rdy, input bit tr);
    tog = !tog;
    cyc(d, tog, m, tr, rdy, 1'b0);
  endtask
  task automatic idle(input int n, input bit rdy);
    repeat (n) cyc(8'h00, tog, 1'b0, 1'b0, rdy, 1'b0);
  endtask
  task automatic do_reset();
    tog = 1'b0;
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, io.char_valid, 0);
    chk({tag, "_data"}, io.char_data, 8'h00);
    chk({tag, "_done"}, io.done, 0);
    chk({tag, "_pass"}, io.pass, 0);
    chk({tag, "_code"}, io.status_code, 8'h00);
    chk({tag, "_ovf"}, io.overflow, 0);
    chk({tag, "_tmo"}, io.timeout, 0);
  endtask

  initial begin
    logic [7:0] hello [3];
    hello = '{8'h48, 8'h69, 8'h0A};
    do_reset();
    chk_reset_state("rst0");
    for (int i = 0; i < 3; i++) begin
      send(hello[i], 1'b0, 1'b1, 1'b0);
      idle(1, 1'b1);
      chk("hello_valid", io.char_valid, 1);
      chk("hello_data", io.char_data, hello[i]);
      idle(1, 1'b1);
    end
    chk("hello_done", io.done, 0);
    do_reset();
    for (int i = 0; i < 17; i++) send(8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("full_ovf", io.overflow, 1);
    chk("full_head", io.char_data, 8'h30);
    idle(20, 1'b1);
    chk("full_drained", io.char_valid, 0);
    do_reset();
    for (int i = 0; i < 17; i++) send(8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("fullpop_ovf", io.overflow, 0);
    chk("fullpop_head", io.char_data, 8'h51);
    idle(20, 1'b1);
    do_reset();
    send(8'h00, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("st0_done", io.done, 1);
    chk("st0_pass", io.pass, 1);
    chk("st0_code", io.status_code, 8'h00);
    do_reset();
    send(8'h05, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("st5_pass", io.pass, 0);
    chk("st5_code", io.status_code, 8'h05);
    send(8'h00, 1'b1, 1'b1, 1'b0);
    send(8'h41, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("st5_sticky", io.status_code, 8'h05);
    chk("st5_nochar", io.char_valid, 0);
    do_reset();
    send(8'h00, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("trap_done", io.done, 1);
    chk("trap_pass", io.pass, 0);
    chk("trap_code", io.status_code, 8'hFF);
    do_reset();
    chk_reset_state("rst1");
`ifdef F8_GPIOMON_TIMEOUT_EN
    idle(7, 1'b1);
    chk("tmo_early", io.done, 0);
    idle(1, 1'b1);
    chk("tmo_done", io.done, 1);
    chk("tmo_flag", io.timeout, 1);
    chk("tmo_code", io.status_code, 8'hFE);
    do_reset();
    idle(6, 1'b1);
    send(8'h11, 1'b0, 1'b1, 1'b0);
    idle(8, 1'b1);
    chk("tmo_restart", io.done, 0);
    idle(1, 1'b1);
    chk("tmo_late", io.timeout, 1);
    do_reset();
`endif
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0 || (m_done && $urandom_range(0, 19) == 0)) do_reset();
      else if ($urandom_range(0, 1) == 1)
        send(8'($urandom), $urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
      else
        cyc(8'($urandom), tog, $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, 1'b0);
    end
    idle(2, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
